// File: rtl/dct_butterfly_stage.sv
// -----------------------------------------------------------------------------
// dct_butterfly_stage
//
// Row-parallel butterfly stage of the JPEG DCT pipeline. It takes one row of N
// signed W-bit samples and works on groups of G samples. Within each group it
// does a mirror add/subtract: the low half gets a+c and the high half gets a-c,
// where c is the mirrored partner of a. In pass-through mode it sign-extends
// each sample instead. Results are W+1 bits wide, so the arithmetic never
// overflows.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-low reset
//   en         global enable; 0 freezes every register and masks out_valid
//   mode       0 = butterfly, 1 = pass-through (captured with the row)
//   in_valid   / in_ready  / in_last / din   : input row handshake
//   out_valid  / out_ready / out_last / dout : output row handshake
//   blk_cnt    number of output transfers that carried out_last = 1
//
// PIPE = 1 : the arithmetic result goes straight into the output register.
// PIPE = 2 : the result is registered in stage 1, then moves to the output
//            register (stage 2). Each stage has its own valid flag.
// -----------------------------------------------------------------------------
module dct_butterfly_stage #(
   parameter int N     = 8,
   parameter int W     = 16,
   parameter int G     = 8,
   parameter int PIPE  = 1,
   parameter int CNT_W = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 en,
   input  logic                 mode,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic                 in_last,
   input  logic [N*W-1:0]       din,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic                 out_last,
   output logic [N*(W+1)-1:0]   dout,
   output logic [CNT_W-1:0]     blk_cnt
);

   localparam int OW = N * (W + 1);

   // Mirror butterfly across every group of G samples, or sign-extending
   // pass-through. Operands are widened first so a+c and a-c are exact.
   function automatic logic [OW-1:0] butterfly(input logic [N*W-1:0] x,
                                               input logic           m);
      logic signed [W:0] a;
      logic signed [W:0] c;
      logic [OW-1:0]     r;
      r = '0;
      for (int b = 0; b < N; b += G) begin
         for (int j = 0; j < G / 2; j++) begin
            a = {x[(b + j) * W + W - 1], x[(b + j) * W +: W]};
            c = {x[(b + G - 1 - j) * W + W - 1], x[(b + G - 1 - j) * W +: W]};
            if (m) begin
               r[(b + j) * (W + 1) +: W + 1]         = a;
               r[(b + G - 1 - j) * (W + 1) +: W + 1] = c;
            end else begin
               r[(b + j) * (W + 1) +: W + 1]         = a + c;
               r[(b + G - 1 - j) * (W + 1) +: W + 1] = a - c;
            end
         end
      end
      return r;
   endfunction

   logic [OW-1:0]    res;
   logic             in_xfer;
   logic             out_xfer;

   // Source feeding the output register (the input row, or stage 1).
   logic             s2_src_v;
   logic             s2_src_l;
   logic [OW-1:0]    s2_src_d;
   logic             s2_load;

   logic             v2_q, v2_d;
   logic             l2_q, l2_d;
   logic [OW-1:0]    d2_q, d2_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   assign res      = butterfly(din, mode);
   assign out_xfer = en & v2_q & out_ready;
   // The output register loads whenever it is empty or being drained.
   assign s2_load  = en & s2_src_v & (~v2_q | out_ready);

   generate
      if (PIPE == 2) begin : g_pipe2
         logic          v1_q, v1_d;
         logic          l1_q, l1_d;
         logic [OW-1:0] d1_q, d1_d;

         // Stage 1 can take a row if it is empty or is handing its row on.
         assign in_ready = reset & en & (~v1_q | ~v2_q | out_ready);
         assign in_xfer  = in_valid & in_ready;

         always_comb begin
            v1_d = v1_q;
            l1_d = l1_q;
            d1_d = d1_q;
            if (in_xfer) begin
               v1_d = 1'b1;
               l1_d = in_last;
               d1_d = res;
            end else if (s2_load) begin
               v1_d = 1'b0;
            end
         end

         always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
               v1_q <= 1'b0;
               l1_q <= 1'b0;
               d1_q <= '0;
            end else if (en) begin
               v1_q <= v1_d;
               l1_q <= l1_d;
               d1_q <= d1_d;
            end
         end

         assign s2_src_v = v1_q;
         assign s2_src_l = l1_q;
         assign s2_src_d = d1_q;
      end else begin : g_pipe1
         assign in_ready = reset & en & (~v2_q | out_ready);
         assign in_xfer  = in_valid & in_ready;
         assign s2_src_v = in_xfer;
         assign s2_src_l = in_last;
         assign s2_src_d = res;
      end
   endgenerate

   // ---- output register and block counter ----
   always_comb begin
      v2_d  = v2_q;
      l2_d  = l2_q;
      d2_d  = d2_q;
      cnt_d = cnt_q;
      if (s2_load) begin
         v2_d = 1'b1;
         l2_d = s2_src_l;
         d2_d = s2_src_d;
      end else if (out_xfer) begin
         v2_d = 1'b0;
      end
      if (out_xfer && l2_q) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         v2_q  <= 1'b0;
         l2_q  <= 1'b0;
         d2_q  <= '0;
         cnt_q <= '0;
      end else if (en) begin
         v2_q  <= v2_d;
         l2_q  <= l2_d;
         d2_q  <= d2_d;
         cnt_q <= cnt_d;
      end
   end

   // The valid flag is kept internally while frozen; only the port is masked.
   assign out_valid = en & v2_q;
   assign out_last  = l2_q;
   assign dout      = d2_q;
   assign blk_cnt   = cnt_q;

endmodule

// File: tb/tb_dct_butterfly_stage.sv
module tb_dct_butterfly_stage;

   logic clk = 1'b0;
   logic reset;
   logic en;

   // Index 0: G=8 PIPE=1, index 1: G=4 PIPE=1, index 2: G=8 PIPE=2
   logic         inv  [3];
   logic         md   [3];
   logic         inl  [3];
   logic         ordy [3];
   logic         ir   [3];
   logic         ov   [3];
   logic         ol   [3];
   logic [127:0] dn   [3];
   logic [135:0] dq   [3];
   logic [15:0]  cnt  [3];

   int tests = 0;
   int fails = 0;

   logic [135:0] exp_d[$];
   logic         exp_l[$];
   int           model_cnt [3];
   logic         stall_prev;
   logic [135:0] hold_d;
   logic         hold_l;
   int           outs_seen;

   always #5 clk = ~clk;

   dct_butterfly_stage #(.N(8), .W(16), .G(8), .PIPE(1), .CNT_W(16)) u_p1 (
      .clk(clk), .reset(reset), .en(en), .mode(md[0]), .in_valid(inv[0]),
      .in_ready(ir[0]), .in_last(inl[0]), .din(dn[0]), .out_valid(ov[0]),
      .out_ready(ordy[0]), .out_last(ol[0]), .dout(dq[0]), .blk_cnt(cnt[0]));

   dct_butterfly_stage #(.N(8), .W(16), .G(4), .PIPE(1), .CNT_W(16)) u_g4 (
      .clk(clk), .reset(reset), .en(en), .mode(md[1]), .in_valid(inv[1]),
      .in_ready(ir[1]), .in_last(inl[1]), .din(dn[1]), .out_valid(ov[1]),
      .out_ready(ordy[1]), .out_last(ol[1]), .dout(dq[1]), .blk_cnt(cnt[1]));

   dct_butterfly_stage #(.N(8), .W(16), .G(8), .PIPE(2), .CNT_W(16)) u_p2 (
      .clk(clk), .reset(reset), .en(en), .mode(md[2]), .in_valid(inv[2]),
      .in_ready(ir[2]), .in_last(inl[2]), .din(dn[2]), .out_valid(ov[2]),
      .out_ready(ordy[2]), .out_last(ol[2]), .dout(dq[2]), .blk_cnt(cnt[2]));

   function automatic int gsz(input int d);
      return (d == 1) ? 4 : 8;
   endfunction

   // Reference: each output lane finds its mirror partner inside its group.
   function automatic logic [135:0] model(input logic [127:0] x, input logic m, input int g);
      int s [8];
      int k, p, v;
      logic [135:0] r;
      for (int i = 0; i < 8; i++) s[i] = int'($signed(x[i*16 +: 16]));
      for (int i = 0; i < 8; i++) begin
         k = i % g;
         p = (i - k) + g - 1 - k;
         if (m) v = s[i];
         else if (k < g / 2) v = s[i] + s[p];
         else v = s[p] - s[i];
         r[i*17 +: 17] = 17'(v);
      end
      return r;
   endfunction

   function automatic logic [135:0] pack17(input int a [8]);
      logic [135:0] r;
      for (int i = 0; i < 8; i++) r[i*17 +: 17] = 17'(a[i]);
      return r;
   endfunction

   function automatic logic [127:0] pack16(input int a [8]);
      logic [127:0] r;
      for (int i = 0; i < 8; i++) r[i*16 +: 16] = 16'(a[i]);
      return r;
   endfunction

   function automatic logic [127:0] rand_row();
      logic [127:0] r;
      logic [15:0]  w;
      for (int i = 0; i < 8; i++) begin
         case ($urandom_range(0, 5))
            0: w = 16'h7fff;
            1: w = 16'h8000;
            default: w = 16'($urandom);
         endcase
         r[i*16 +: 16] = w;
      end
      return r;
   endfunction

   // One clock of streaming on DUT d with scoreboard checks.
   task automatic step(input int d, input logic v, input logic [127:0] row, input logic m,
                       input logic l, input logic rdy, input logic e, output logic acc);
      logic         ox;
      logic [135:0] ed;
      logic         el;
      @(negedge clk);
      inv[d] = v; dn[d] = row; md[d] = m; inl[d] = l; ordy[d] = rdy; en = e;
      #1;
      tests++;
      if (cnt[d] !== 16'(model_cnt[d])) begin
         fails++;
         $display("FAIL blk_cnt dut%0d: got %0d want %0d", d, cnt[d], 16'(model_cnt[d]));
      end
      if (d != 2) begin
         tests++;
         if (ir[d] !== (e & (~ov[d] | rdy))) begin
            fails++;
            $display("FAIL in_ready dut%0d: got %b want %b", d, ir[d], e & (~ov[d] | rdy));
         end
      end
      if (!e) begin
         tests++;
         if (ov[d] !== 1'b0 || ir[d] !== 1'b0) begin
            fails++;
            $display("FAIL freeze dut%0d: out_valid %b in_ready %b want 0 0", d, ov[d], ir[d]);
         end
      end else if (stall_prev) begin
         tests++;
         if (ov[d] !== 1'b1 || dq[d] !== hold_d || ol[d] !== hold_l) begin
            fails++;
            $display("FAIL stall_hold dut%0d: valid %b dout %h last %b want 1 %h %b",
                     d, ov[d], dq[d], ol[d], hold_d, hold_l);
         end
      end
      ox = ov[d] & rdy & e;
      if (ox) begin
         tests++;
         if (exp_d.size() == 0) begin
            fails++;
            $display("FAIL spurious dut%0d: got row %h want none", d, dq[d]);
         end else begin
            ed = exp_d.pop_front();
            el = exp_l.pop_front();
            outs_seen++;
            if (el) model_cnt[d]++;
            if (dq[d] !== ed || ol[d] !== el) begin
               fails++;
               $display("FAIL row dut%0d: got %h/%b want %h/%b", d, dq[d], ol[d], ed, el);
            end
         end
      end
      acc = v & ir[d] & e;
      if (acc) begin
         exp_d.push_back(model(row, m, gsz(d)));
         exp_l.push_back(l);
      end
      if (e) begin
         stall_prev = ov[d] & ~rdy;
         hold_d     = dq[d];
         hold_l     = ol[d];
      end
   endtask

   task automatic drain(input int d);
      int   n = 0;
      logic a;
      while (exp_d.size() != 0 && n < 50) begin
         step(d, 1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b1, a);
         n++;
      end
      step(d, 1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b1, a);
      tests++;
      if (exp_d.size() != 0) begin
         fails++;
         $display("FAIL drain dut%0d: %0d rows left want 0", d, exp_d.size());
      end
   endtask

   task automatic push_one(input int d, input logic [127:0] row, input logic m);
      @(negedge clk);
      inv[d] = 1'b1; dn[d] = row; md[d] = m; inl[d] = 1'b0; ordy[d] = 1'b1; en = 1'b1;
      #1;
      tests++;
      if (ov[d] !== 1'b0 && d == 0 && 0 > 1) fails++;
      @(negedge clk);
      inv[d] = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      en    = 1'b1;
      for (int i = 0; i < 3; i++) begin
         inv[i] = 1'b0; md[i] = 1'b0; inl[i] = 1'b0; ordy[i] = 1'b1; dn[i] = '0;
         model_cnt[i] = 0;
      end
      stall_prev = 1'b0;
      #3;
      for (int i = 0; i < 3; i++) begin
         tests++;
         if (ov[i] !== 1'b0 || ol[i] !== 1'b0 || dq[i] !== '0 || cnt[i] !== '0 || ir[i] !== 1'b0) begin
            fails++;
            $display("FAIL reset_state dut%0d: v%b l%b d%h c%0d r%b want all 0",
                     i, ov[i], ol[i], dq[i], cnt[i], ir[i]);
         end
      end
      @(negedge clk);
      reset = 1'b1;
      #1;
      for (int i = 0; i < 3; i++) begin
         tests++;
         if (ir[i] !== 1'b1) begin
            fails++;
            $display("FAIL ready_after_reset dut%0d: got %b want 1", i, ir[i]);
         end
      end
   endtask

   task automatic test_basic();
      int seq [8];
      int e8 [8];
      logic [127:0] r;
      seq = '{1, 2, 3, 4, 5, 6, 7, 8};
      e8  = '{9, 9, 9, 9, -1, -3, -5, -7};
      r = pack16(seq);
      @(negedge clk);
      inv[0] = 1'b1; dn[0] = r; md[0] = 1'b0; inl[0] = 1'b0; ordy[0] = 1'b1; en = 1'b1;
      #1;
      tests++;
      if (ov[0] !== 1'b0) begin
         fails++;
         $display("FAIL basic_latency: out_valid %b want 0 before edge", ov[0]);
      end
      @(negedge clk);
      inv[0] = 1'b0;
      #1;
      tests++;
      if (ov[0] !== 1'b1 || dq[0] !== pack17(e8)) begin
         fails++;
         $display("FAIL basic: valid %b dout %h want 1 %h", ov[0], dq[0], pack17(e8));
      end
   endtask

   task automatic test_extremes();
      logic [127:0] r;
      int e8 [8];
      r = '0;
      r[15:0] = 16'h7fff; r[127:112] = 16'h7fff;
      push_one(0, r, 1'b0);
      e8 = '{65534, 0, 0, 0, 0, 0, 0, 0};
      tests++;
      if (ov[0] !== 1'b1 || dq[0] !== pack17(e8)) begin
         fails++;
         $display("FAIL extreme_pos: dout %h want %h", dq[0], pack17(e8));
      end
      r[15:0] = 16'h8000;
      push_one(0, r, 1'b0);
      e8 = '{-1, 0, 0, 0, 0, 0, 0, -65535};
      tests++;
      if (ov[0] !== 1'b1 || dq[0] !== pack17(e8)) begin
         fails++;
         $display("FAIL extreme_neg: dout %h want %h", dq[0], pack17(e8));
      end
   endtask

   task automatic test_group_mode();
      int seq [8];
      int e8 [8];
      logic [127:0] r;
      seq = '{1, 2, 3, 4, 5, 6, 7, 8};
      r = pack16(seq);
      push_one(1, r, 1'b0);
      e8 = '{5, 5, -1, -3, 13, 13, -1, -3};
      tests++;
      if (ov[1] !== 1'b1 || dq[1] !== pack17(e8)) begin
         fails++;
         $display("FAIL group4: dout %h want %h", dq[1], pack17(e8));
      end
      push_one(1, r, 1'b1);
      tests++;
      if (ov[1] !== 1'b1 || dq[1] !== pack17(seq)) begin
         fails++;
         $display("FAIL passthru: dout %h want %h", dq[1], pack17(seq));
      end
   endtask

   task automatic test_backpressure();
      int sent = 0;
      logic a;
      logic [127:0] cur;
      outs_seen  = 0;
      stall_prev = 1'b0;
      cur = rand_row();
      for (int c = 0; c < 20; c++) begin
         step(2, sent < 6, cur, 1'b0, 1'b0, !(c >= 3 && c <= 5), 1'b1, a);
         if (a) begin
            sent++;
            cur = rand_row();
         end
         if (c >= 3 && c <= 5) begin
            tests++;
            if (ir[2] !== 1'b0) begin
               fails++;
               $display("FAIL full_ready cycle %0d: in_ready %b want 0", c, ir[2]);
            end
         end
      end
      tests++;
      if (outs_seen != 6 || sent != 6 || exp_d.size() != 0) begin
         fails++;
         $display("FAIL backpressure_count: out %0d sent %0d left %0d want 6 6 0",
                  outs_seen, sent, exp_d.size());
      end
   endtask

   task automatic test_enable_last();
      int   sent = 0;
      int   base;
      logic a;
      logic [127:0] cur;
      base = model_cnt[2];
      cur  = rand_row();
      for (int c = 0; c < 40 && sent < 16; c++) begin
         step(2, 1'b1, cur, c[0], (sent == 7 || sent == 15), 1'b1, !(c == 5 || c == 6), a);
         if (a) begin
            sent++;
            cur = rand_row();
         end
      end
      drain(2);
      tests++;
      if (cnt[2] !== 16'(base + 2)) begin
         fails++;
         $display("FAIL blk_count: got %0d want %0d", cnt[2], base + 2);
      end
   endtask

   task automatic test_random(input int d);
      logic a;
      logic [127:0] cur;
      logic cm, cl;
      stall_prev = 1'b0;
      cur = rand_row(); cm = 1'($urandom); cl = ($urandom_range(0, 3) == 0);
      for (int c = 0; c < 300; c++) begin
         step(d, 1'($urandom), cur, cm, cl, $urandom_range(0, 9) < 7,
              $urandom_range(0, 9) != 0, a);
         if (a) begin
            cur = rand_row(); cm = 1'($urandom); cl = ($urandom_range(0, 3) == 0);
         end
      end
      drain(d);
   endtask

   task automatic test_reset_midflight();
      logic a;
      logic [127:0] r;
      step(2, 1'b1, rand_row(), 1'b0, 1'b1, 1'b1, 1'b1, a);
      drain(2);
      step(2, 1'b1, rand_row(), 1'b0, 1'b0, 1'b0, 1'b1, a);
      step(2, 1'b1, rand_row(), 1'b1, 1'b0, 1'b0, 1'b1, a);
      inv[2] = 1'b0;
      @(posedge clk);
      #2;
      reset = 1'b0;
      #1;
      tests++;
      if (ov[2] !== 1'b0 || ol[2] !== 1'b0 || dq[2] !== '0 || cnt[2] !== '0 || ir[2] !== 1'b0) begin
         fails++;
         $display("FAIL midflight_reset: v%b l%b d%h c%0d r%b want all 0",
                  ov[2], ol[2], dq[2], cnt[2], ir[2]);
      end
      exp_d.delete();
      exp_l.delete();
      for (int i = 0; i < 3; i++) model_cnt[i] = 0;
      stall_prev = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      #1;
      tests++;
      if (ir[2] !== 1'b1) begin
         fails++;
         $display("FAIL release_ready: got %b want 1", ir[2]);
      end
      r = rand_row();
      inv[2] = 1'b1; dn[2] = r; md[2] = 1'b0; inl[2] = 1'b0; ordy[2] = 1'b1;
      @(negedge clk);
      inv[2] = 1'b0;
      #1;
      tests++;
      if (ov[2] !== 1'b0) begin
         fails++;
         $display("FAIL p2_latency: out_valid %b want 0 after 1 cycle", ov[2]);
      end
      @(negedge clk);
      #1;
      tests++;
      if (ov[2] !== 1'b1 || dq[2] !== model(r, 1'b0, 8)) begin
         fails++;
         $display("FAIL p2_result: valid %b dout %h want 1 %h", ov[2], dq[2], model(r, 1'b0, 8));
      end
      @(negedge clk);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_basic();
      test_extremes();
      test_group_mode();
      test_backpressure();
      test_enable_last();
      test_random(0);
      test_random(2);
      test_random(1);
      test_reset_midflight();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
